// File: rtl/button_debouncer_if.sv
// Button pin in, debounced level/strobes/press count out, bundled for one debouncer instance.
interface button_debouncer_if;
  logic       btn_in;
  logic       btn_level;
  logic       press;
  logic       release_pulse;
  logic       long_press;
  logic       repeat_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, press, release_pulse, long_press, repeat_pulse, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, press, release_pulse, long_press, repeat_pulse, press_count
  );
endinterface

// File: rtl/button_debouncer.sv
// Raw button pin -> synced, debounced level with press/release/long-press strobes and press count; auto-repeat under BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
// Latency: DEBOUNCE_CYCLES+2 cycles from stable pin edge to level/strobe; no backpressure, strobes are one-cycle and must be consumed when seen.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  button_debouncer_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("button_debouncer: cycle parameters must all be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ARM_DN, DOWN, ARM_UP} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic          press_nxt, rel_nxt;
  logic          s1, s2, p;
  logic          level_q, press_q, rel_q, long_q;
  logic [HW-1:0] hcnt;
  logic          held, long_set, rpt_set;
  logic [7:0]    count_q;

  // Flops reset to the idle pin level so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
    end else begin
      s1 <= bus.btn_in;
      s2 <= s1;
    end
  end

  assign p = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = DOWN;
            press_nxt = 1'b1;
          end else begin
            state_nxt = ARM_DN;
            dcnt_nxt  = DW'(1);
          end
        end
      end
      ARM_DN: begin
        if (!p) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt == D_LAST) begin
          state_nxt = DOWN;
          dcnt_nxt  = '0;
          press_nxt = 1'b1;
        end else begin
          dcnt_nxt  = dcnt + DW'(1);
        end
      end
      DOWN: begin
        if (!p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = IDLE;
            rel_nxt   = 1'b1;
          end else begin
            state_nxt = ARM_UP;
            dcnt_nxt  = DW'(1);
          end
        end
      end
      ARM_UP: begin
        if (p) begin
          state_nxt = DOWN;
          dcnt_nxt  = '0;
        end else if (dcnt == D_LAST) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
          rel_nxt   = 1'b1;
        end else begin
          dcnt_nxt  = dcnt + DW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end

  assign held     = (state == DOWN) || (state == ARM_UP);
  assign long_set = held && !rel_nxt && (hcnt == H_LAST);

  // Hold counter saturates at LONG_CYCLES so the long strobe fires once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= long_set;
      if (press_nxt || rel_nxt) begin
        hcnt <= '0;
      end else if (held && hcnt != H_MAX) begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic          rpt_on, rpt_q;
  logic [RW-1:0] rcnt;

  assign rpt_set = rpt_on && held && !rel_nxt && (rcnt == R_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_on <= 1'b0;
      rcnt   <= '0;
      rpt_q  <= 1'b0;
    end else begin
      rpt_q <= rpt_set;
      if (rel_nxt) begin
        rpt_on <= 1'b0;
        rcnt   <= '0;
      end else if (long_set) begin
        rpt_on <= 1'b1;
        rcnt   <= '0;
      end else if (rpt_on && held) begin
        rcnt   <= rpt_set ? '0 : rcnt + RW'(1);
      end
    end
  end

  assign bus.repeat_pulse = rpt_q;
`else
  assign rpt_set          = 1'b0;
  assign bus.repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= '0;
    end else begin
      level_q <= (state_nxt == DOWN) || (state_nxt == ARM_UP);
      press_q <= press_nxt;
      rel_q   <= rel_nxt;
      if (press_nxt || rpt_set) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_press    = long_q;
  assign bus.press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE=4, LONG=10, REPEAT=3, active-low pin.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_debouncer_if bus();

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .REPEAT_CYCLES  (3),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic       btn;
    logic       rst;
    logic       lvl;
    logic       prs;
    logic       rel;
    logic       lng;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic btn, input logic rst, input logic lvl,
                     input logic prs, input logic rel, input logic lng, input logic [7:0] cnt);
    vec_t v;
    v.btn = btn; v.rst = rst; v.lvl = lvl; v.prs = prs;
    v.rel = rel; v.lng = lng; v.cnt = cnt;
    repeat (n) vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  exp_cnt;
    bit  found;
    bit  exp_rpt;
    int  seen;
    int  both;

    bus.btn_in = 1'b1;

    // reset, clean press (strobe 6 cycles after edge), release 6 cycles after edge
    add(2, 1, 0, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0, 0);
    add(5, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0, 1);
    add(2, 0, 1, 1, 0, 0, 0, 1);
    add(5, 1, 1, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1, 0, 1);
    add(3, 1, 1, 0, 0, 0, 0, 1);
    // 1-cycle and 3-cycle low glitches are rejected
    add(1, 0, 1, 0, 0, 0, 0, 1);
    add(8, 1, 1, 0, 0, 0, 0, 1);
    add(3, 0, 1, 0, 0, 0, 0, 1);
    add(8, 1, 1, 0, 0, 0, 0, 1);
    // exactly 4 low cycles is the shortest accepted press
    add(4, 0, 1, 0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, 1);
    add(1, 1, 1, 1, 1, 0, 0, 2);
    add(3, 1, 1, 1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 0, 1, 0, 2);
    add(2, 1, 1, 0, 0, 0, 0, 2);
    // bounce 2 low / 2 high for 20 cycles
    for (int i = 0; i < 5; i++) begin
      add(2, 0, 1, 0, 0, 0, 0, 2);
      add(2, 1, 1, 0, 0, 0, 0, 2);
    end
    add(6, 1, 1, 0, 0, 0, 0, 2);

    foreach (vt[i]) begin
      bus.btn_in = vt[i].btn;
      rst_n      = vt[i].rst;
      step();
      check($sformatf("vec%0d_level", i), bus.btn_level,     vt[i].lvl);
      check($sformatf("vec%0d_press", i), bus.press,         vt[i].prs);
      check($sformatf("vec%0d_rel", i),   bus.release_pulse, vt[i].rel);
      check($sformatf("vec%0d_long", i),  bus.long_press,    vt[i].lng);
      check($sformatf("vec%0d_rpt", i),   bus.repeat_pulse,  1'b0);
      check($sformatf("vec%0d_count", i), bus.press_count,   vt[i].cnt);
    end

    // long press: one LONG_PRESS at +10, repeats at +13, +16, ... when built in
    exp_cnt = 2;
    bus.btn_in = 1'b0;
    found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      step();
      if (bus.press) begin
        found = 1'b1;
        check("long_press_latency", i, 6);
      end
    end
    if (!found) check("long_press_seen", 0, 1);
    exp_cnt++;
    check("long_count_after_press", bus.press_count, exp_cnt);
    for (int k = 1; k <= 30; k++) begin
      step();
`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
      exp_rpt = (k >= 13) && ((k - 10) % 3 == 0);
`else
      exp_rpt = 1'b0;
`endif
      if (exp_rpt) exp_cnt++;
      check($sformatf("hold%0d_long", k),  bus.long_press,   (k == 10));
      check($sformatf("hold%0d_rpt", k),   bus.repeat_pulse, exp_rpt);
      check($sformatf("hold%0d_count", k), bus.press_count,  exp_cnt);
      check($sformatf("hold%0d_level", k), bus.btn_level,    1'b1);
    end
    bus.btn_in = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      step();
      if (bus.release_pulse) begin
        found = 1'b1;
        check("long_release_latency", i, 6);
        check("long_release_level", bus.btn_level, 1'b0);
      end
    end
    if (!found) check("long_release_seen", 0, 1);
    step();
    check("after_release_count", bus.press_count, exp_cnt);

    // reset mid-debounce (dcnt=2), button kept held across reset release
    bus.btn_in = 1'b0;
    repeat (4) step();
    check("middb_level_pre", bus.btn_level, 1'b0);
    rst_n = 1'b0;
    #1;
    check("middb_rst_level", bus.btn_level,     1'b0);
    check("middb_rst_press", bus.press,         1'b0);
    check("middb_rst_rel",   bus.release_pulse, 1'b0);
    check("middb_rst_long",  bus.long_press,    1'b0);
    check("middb_rst_rpt",   bus.repeat_pulse,  1'b0);
    check("middb_rst_count", bus.press_count,   8'd0);
    step();
    step();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 12 && !found; i++) begin
      step();
      if (bus.press) begin
        found = 1'b1;
        check("postrst_press_latency", i, 6);
        check("postrst_count", bus.press_count, 8'd1);
      end
    end
    if (!found) check("postrst_press_seen", 0, 1);

    // wrap: 256 short presses from a fresh reset
    bus.btn_in = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("wrap_start_count", bus.press_count, 8'd0);
    seen = 0;
    both = 0;
    for (int n = 0; n < 256; n++) begin
      bus.btn_in = 1'b0;
      for (int c = 0; c < 8; c++) begin
        step();
        if (bus.press) seen++;
        if (bus.press && bus.release_pulse) both++;
      end
      bus.btn_in = 1'b1;
      for (int c = 0; c < 8; c++) begin
        step();
        if (bus.press) seen++;
        if (bus.press && bus.release_pulse) both++;
      end
      if (n == 254) check("wrap_count_255", bus.press_count, 8'd255);
    end
    check("wrap_presses_seen", seen, 256);
    check("wrap_count_0", bus.press_count, 8'd0);
    check("wrap_strobe_overlap", both, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
